glip_downscale_n: RTL and testbench
===================================

Name: glip_downscale_n

Overview:
- Generalised FIFO-interface width downscaler. Splits each input word of RATIO*OUT_SIZE bits into up to RATIO output beats of OUT_SIZE bits.
- Adds three things: selectable beat order, partial-word transfers via a per-word beat count, and a last-beat marker.
- Fully registered output with zero-bubble back-to-back throughput.
- Sits between wide host-side logic FIFOs and narrow target/link FIFOs in GLIP backends.

Parameters:
- OUT_SIZE, 16, output beat width in bits; input width is OUT_SIZE*RATIO.
- RATIO, 4, number of output beats per full input word; legal values 2..64.
- MSB_FIRST, 0, 0 emits the least significant slice first; 1 emits the most significant slice first.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  OUT_SIZE*RATIO  wide input word.
- in_count  input  $clog2(RATIO)  number of valid beats minus one (k means k+1 beats).
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts the input word this cycle.
- out_data  output  OUT_SIZE  current output beat.
- out_last  output  1  current beat is the final beat of its input word.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- One clock. Reset is asynchronous and active-high on rst.
- State:
  - busy (1 bit)
  - data_q holding register (OUT_SIZE*RATIO bits)
  - cnt_q (last beat index)
  - idx beat counter, $clog2(RATIO) bits
- Reset values: busy=0, idx=0, cnt_q=0, data_q=0. Therefore out_valid=0, out_last=0, in_ready=1, and out_data=slice 0 of zero, i.e. 0.
- States:
  - IDLE (busy=0): in_ready=1, out_valid=0.
  - EMIT (busy=1): out_valid=1.
- Output mapping:
  - out_valid = busy.
  - out_last = busy & (idx==cnt_q).
  - MSB_FIRST=0: out_data = data_q[idx*OUT_SIZE +: OUT_SIZE].
  - MSB_FIRST=1: out_data = data_q[(RATIO-1-idx)*OUT_SIZE +: OUT_SIZE].
  - With MSB_FIRST=1 and a partial count, beats come from the top slices downward.
- in_ready = !busy | (out_ready & idx==cnt_q). This is combinational from out_ready and the registered state.
- Accept (in_valid & in_ready): data_q<=in_data, cnt_q<=in_count, idx<=0, busy<=1.
- Beat transfer (out_valid & out_ready):
  - idx!=cnt_q: idx<=idx+1.
  - idx==cnt_q with no simultaneous accept: busy<=0, idx<=0.
- Simultaneous final-beat transfer and accept: the accept wins. The new word is loaded, idx=0, busy stays 1, so there is no idle cycle between words.
- Latency: first beat is valid in the cycle after acceptance. Throughput is cnt+1 beats per word with no bubbles under continuous out_ready.
- Backpressure: while out_ready=0, out_data, out_last and idx hold. in_ready=0 while busy.
- in_count > RATIO-1 (non-power-of-two RATIO) is illegal. Behaviour is undefined; the bench asserts it never occurs.
- in_data and in_count are sampled only on accept. Changes while in_valid=0 or in_ready=0 have no effect.
- Asynchronous reset mid-word drops the remaining beats immediately. out_valid goes 0 with no clock edge required.
- No combinational path from in_valid or in_data to any output.

Test Plan:
- Full word, ordering. OUT_SIZE=8, RATIO=4, MSB_FIRST=0, out_ready=1. Accept 0x44332211 with in_count=3 → beats 0x11,0x22,0x33,0x44 on four consecutive cycles starting one cycle after accept. out_last=1 only on 0x44.
- Back-to-back. Words 0x44332211 then 0x88776655 held valid → eight consecutive beats with no gap. in_ready=1 on the 0x44 cycle. out_last on 0x44 and 0x88.
- Partial word. in_count=1 on 0xDDCCBBAA → beats 0xAA,0xBB only, out_last on 0xBB. Next word accepted in the 0xBB cycle.
- MSB_FIRST=1:
  - 0x44332211, count 3 → 0x44,0x33,0x22,0x11.
  - count 0 → single beat 0x44 with out_last=1.
- Backpressure. Toggle out_ready in a 1,0,0,1,0,1,1 pattern during a 4-beat word → each beat is held stable while stalled, exactly four beats delivered in order, in_ready=0 until the final-beat handshake.
- Reset mid-word. Assert rst asynchronously after beat 0x22 → out_valid and out_last drop without a clock edge, in_ready=1 after release, and a fresh word restarts from idx 0.

Source files
------------

// File: rtl/glip_downscale_n.sv
// Width downscaler: splits each RATIO*OUT_SIZE-bit word into up to RATIO beats of
// OUT_SIZE bits. Beat order is selectable, and the last beat of each word is marked.
module glip_downscale_n #(
  parameter int OUT_SIZE  = 16,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OUT_SIZE*RATIO-1:0] in_data,
  input  logic [$clog2(RATIO)-1:0]  in_count,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUT_SIZE-1:0]       out_data,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int CW = $clog2(RATIO);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                    r_state;
  logic [OUT_SIZE*RATIO-1:0] r_data;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             r_idx;

  logic                      w_busy, w_last, w_accept, w_xfer;
  logic [CW-1:0]             w_sel;
  logic [OUT_SIZE-1:0]       w_slice [RATIO];

  assign w_busy   = (r_state == EMIT);
  assign w_last   = (r_idx == r_cnt);
  assign w_xfer   = w_busy & out_ready;
  // The next word may load in the same cycle as the final beat's handshake.
  assign in_ready = !w_busy | (out_ready & w_last);
  assign w_accept = in_valid & in_ready;

  assign out_valid = w_busy;
  assign out_last  = w_busy & w_last;

  genvar g;
  generate
    for (g = 0; g < RATIO; g++) begin : g_slice
      assign w_slice[g] = r_data[g*OUT_SIZE +: OUT_SIZE];
    end
  endgenerate

  // When MSB_FIRST is set, a partial word still starts at the top slice.
  assign w_sel    = MSB_FIRST ? (CW'(RATIO-1) - r_idx) : r_idx;
  assign out_data = w_slice[w_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= in_data;
            r_cnt   <= in_count;
            r_idx   <= '0;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_accept) begin
            r_data  <= in_data;
            r_cnt   <= in_count;
            r_idx   <= '0;
          end else if (w_xfer) begin
            if (!w_last) begin
              r_idx <= r_idx + 1'b1;
            end else begin
              r_idx   <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_glip_downscale_n.sv
// Directed bench for glip_downscale_n: one LSB-first and one MSB-first instance
// (8-bit beats, 4 beats per word) with hand-computed beat sequences.
module tb_glip_downscale_n;
  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] a_in_data, b_in_data;
  logic [1:0]  a_in_count, b_in_count;
  logic        a_in_valid, b_in_valid, a_in_ready, b_in_ready;
  logic [7:0]  a_out_data, b_out_data;
  logic        a_out_last, b_out_last, a_out_valid, b_out_valid;
  logic        a_out_ready, b_out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  glip_downscale_n #(.OUT_SIZE(8), .RATIO(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_count(a_in_count), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_last(a_out_last), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  glip_downscale_n #(.OUT_SIZE(8), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_count(b_in_count), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  // Counts must stay within RATIO-1 beats; with RATIO=4 every 2-bit code is legal.
  always @(posedge clk) begin
    if (a_in_valid) assert (int'(a_in_count) <= 3);
    if (b_in_valid) assert (int'(b_in_count) <= 3);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample one cycle mid-period, then advance to just after the next edge.
  task automatic beat(input bit b, input string tag, input logic [7:0] d, input bit l, input bit r);
    #3;
    check({tag, " valid"}, b ? b_out_valid : a_out_valid, 1);
    check({tag, " data"},  b ? b_out_data  : a_out_data,  d);
    check({tag, " last"},  b ? b_out_last  : a_out_last,  l);
    check({tag, " ready"}, b ? b_in_ready  : a_in_ready,  r);
    tick();
  endtask

  task automatic idle(input bit b, input string tag);
    #3;
    check({tag, " valid"}, b ? b_out_valid : a_out_valid, 0);
    check({tag, " ready"}, b ? b_in_ready  : a_in_ready,  1);
    tick();
  endtask

  logic [7:0] bp_d [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44};
  logic       bp_r [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b0;
    a_in_data = '0; a_in_count = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_count = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst valid", a_out_valid, 0);
    check("rst last",  a_out_last,  0);
    check("rst ready", a_in_ready,  1);
    check("rst data",  a_out_data,  0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Full word, LSB first
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_count = 2'd3;
    #3;
    check("full acc ready", a_in_ready, 1);
    check("full acc valid", a_out_valid, 0);
    tick();
    a_in_valid = 1'b0;
    beat(0, "full b0", 8'h11, 0, 0);
    beat(0, "full b1", 8'h22, 0, 0);
    beat(0, "full b2", 8'h33, 0, 0);
    beat(0, "full b3", 8'h44, 1, 1);
    idle(0, "full end");

    // Back-to-back words held valid
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_count = 2'd3;
    tick();
    a_in_data = 32'h88776655;
    beat(0, "b2b b0", 8'h11, 0, 0);
    beat(0, "b2b b1", 8'h22, 0, 0);
    beat(0, "b2b b2", 8'h33, 0, 0);
    beat(0, "b2b b3", 8'h44, 1, 1);
    a_in_valid = 1'b0;
    beat(0, "b2b b4", 8'h55, 0, 0);
    beat(0, "b2b b5", 8'h66, 0, 0);
    beat(0, "b2b b6", 8'h77, 0, 0);
    beat(0, "b2b b7", 8'h88, 1, 1);
    idle(0, "b2b end");

    // Partial word, next word taken on its final beat
    a_in_valid = 1'b1; a_in_data = 32'hDDCCBBAA; a_in_count = 2'd1;
    tick();
    a_in_data = 32'h44332211; a_in_count = 2'd3;
    beat(0, "part b0", 8'hAA, 0, 0);
    beat(0, "part b1", 8'hBB, 1, 1);
    a_in_valid = 1'b0;
    beat(0, "part n0", 8'h11, 0, 0);
    beat(0, "part n1", 8'h22, 0, 0);
    beat(0, "part n2", 8'h33, 0, 0);
    beat(0, "part n3", 8'h44, 1, 1);
    idle(0, "part end");

    // MSB first: full, single beat, partial
    b_in_valid = 1'b1; b_in_data = 32'h44332211; b_in_count = 2'd3;
    tick();
    b_in_valid = 1'b0;
    beat(1, "msb b0", 8'h44, 0, 0);
    beat(1, "msb b1", 8'h33, 0, 0);
    beat(1, "msb b2", 8'h22, 0, 0);
    beat(1, "msb b3", 8'h11, 1, 1);
    idle(1, "msb end");
    b_in_valid = 1'b1; b_in_count = 2'd0;
    tick();
    b_in_valid = 1'b0;
    beat(1, "msb single", 8'h44, 1, 1);
    idle(1, "msb single end");
    b_in_valid = 1'b1; b_in_data = 32'hDDCCBBAA; b_in_count = 2'd1;
    tick();
    b_in_valid = 1'b0;
    beat(1, "msb part b0", 8'hDD, 0, 0);
    beat(1, "msb part b1", 8'hCC, 1, 1);
    idle(1, "msb part end");

    // Backpressure 1,0,0,1,0,1,1
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_count = 2'd3;
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_out_ready = bp_r[i];
      beat(0, $sformatf("bp c%0d", i), bp_d[i], (i == 6), (i == 6));
    end
    a_out_ready = 1'b1;
    idle(0, "bp end");

    // Asynchronous reset mid-word
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_count = 2'd3;
    tick();
    a_in_valid = 1'b0;
    beat(0, "arst b0", 8'h11, 0, 0);
    beat(0, "arst b1", 8'h22, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst valid", a_out_valid, 0);
    check("arst last",  a_out_last,  0);
    #2 rst = 1'b0;
    tick();
    a_in_valid = 1'b1; a_in_data = 32'h88776655; a_in_count = 2'd3;
    #3;
    check("arst post ready", a_in_ready,  1);
    check("arst post valid", a_out_valid, 0);
    tick();
    a_in_valid = 1'b0;
    beat(0, "arst n0", 8'h55, 0, 0);
    beat(0, "arst n1", 8'h66, 0, 0);
    beat(0, "arst n2", 8'h77, 0, 0);
    beat(0, "arst n3", 8'h88, 1, 1);
    idle(0, "arst end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
